// File: rtl/svreal_sumdiff_pkg.sv
// Shared helpers for the svreal sum/difference decoder.
// Exponent alignment, internal width and shift arithmetic.
package svreal_sumdiff_pkg;

  // The halving of s+d and s-d is folded into the exponent.
  localparam int HALF_EXP_OFS = 1;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int calc_align_exp(input int s_exp, input int d_exp);
    return (s_exp < d_exp) ? s_exp : d_exp;
  endfunction

  function automatic int calc_int_width(
    input int s_width, input int s_exp,
    input int d_width, input int d_exp
  );
    int e;
    e = calc_align_exp(s_exp, d_exp);
    return max2(s_width + s_exp - e, d_width + d_exp - e) + 1;
  endfunction

  function automatic int calc_shift(input int in_exp, input int out_exp);
    return in_exp - out_exp;
  endfunction

endpackage

// File: rtl/svreal_rescale_sat.sv
// Combinational fixed-point rescale: shift, round half up
// and saturate to the output format.
module svreal_rescale_sat
  import svreal_sumdiff_pkg::*;
#(
  parameter int IN_W    = 20,
  parameter int IN_EXP  = -12,
  parameter int OUT_W   = 16,
  parameter int OUT_EXP = -8
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  localparam int SH  = calc_shift(IN_EXP, OUT_EXP);
  localparam int LSH = (SH > 0) ? SH : 0;
  localparam int RSH = (SH < 0) ? -SH : 0;
  localparam int XW  =
    max2(max2(IN_W, RSH + 1) + LSH + 1, OUT_W + 1);

  localparam logic signed [XW-1:0] MAXV =
    XW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] val;
  logic signed [XW-1:0] sat;

  assign ext = {{(XW-IN_W){x[IN_W-1]}}, x};

  if (RSH > 0) begin : g_rnd
    localparam logic signed [XW-1:0] HALF =
      XW'(64'sd1 <<< (RSH - 1));
    assign val = (ext + HALF) >>> RSH;
  end else begin : g_lsh
    assign val = ext <<< LSH;
  end

  // Clamp to the output range and flag any clamp.
  always_comb begin
    ovf = 1'b0;
    sat = val;
    if (val > MAXV) begin
      sat = MAXV;
      ovf = 1'b1;
    end else if (val < MINV) begin
      sat = MINV;
      ovf = 1'b1;
    end
  end

  assign y = OUT_W'(sat);

endmodule

// File: rtl/svreal_sumdiff_decode.sv
// Recovers a=(s+d)/2 and b=(s-d)/2 from svreal s/d pairs
// through a 2-stage elastic valid/ready pipeline.
module svreal_sumdiff_decode
  import svreal_sumdiff_pkg::*;
#(
  parameter int S_WIDTH = 18,
  parameter int S_EXP   = -10,
  parameter int D_WIDTH = 19,
  parameter int D_EXP   = -11,
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [S_WIDTH-1:0] s,
  input  logic signed [D_WIDTH-1:0] d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [A_WIDTH-1:0] a,
  output logic signed [B_WIDTH-1:0] b,
  output logic                      ovf_a,
  output logic                      ovf_b
);

  localparam int E    = calc_align_exp(S_EXP, D_EXP);
  localparam int W    =
    calc_int_width(S_WIDTH, S_EXP, D_WIDTH, D_EXP);
  localparam int SSH  = S_EXP - E;
  localparam int DSH  = D_EXP - E;
  localparam int HEXP = E - HALF_EXP_OFS;

  logic signed [W-1:0] s_al, d_al;
  logic signed [W-1:0] sum_q, dif_q;
  logic signed [A_WIDTH-1:0] a_n;
  logic signed [B_WIDTH-1:0] b_n;
  logic ovf_a_n, ovf_b_n;
  logic v1, v2, adv1, adv2;

  assign s_al = {{(W-S_WIDTH){s[S_WIDTH-1]}}, s} <<< SSH;
  assign d_al = {{(W-D_WIDTH){d[D_WIDTH-1]}}, d} <<< DSH;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  svreal_rescale_sat #(
    .IN_W(W), .IN_EXP(HEXP),
    .OUT_W(A_WIDTH), .OUT_EXP(A_EXP)
  ) u_rs_a (
    .x(sum_q), .y(a_n), .ovf(ovf_a_n)
  );

  svreal_rescale_sat #(
    .IN_W(W), .IN_EXP(HEXP),
    .OUT_W(B_WIDTH), .OUT_EXP(B_EXP)
  ) u_rs_b (
    .x(dif_q), .y(b_n), .ovf(ovf_b_n)
  );

  // Stage 1: exact aligned sum and difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sum_q <= '0;
      dif_q <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        sum_q <= s_al + d_al;
        dif_q <= s_al - d_al;
      end
    end
  end

  // Stage 2: rescaled, rounded, saturated outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      a     <= '0;
      b     <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        a     <= a_n;
        b     <= b_n;
        ovf_a <= ovf_a_n;
        ovf_b <= ovf_b_n;
      end
    end
  end

endmodule

// File: tb/tb_svreal_sumdiff_decode.sv
// Self-checking bench for svreal_sumdiff_decode.
// Directed vectors plus a real-valued reference stream.
module tb_svreal_sumdiff_decode;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] s;
  logic signed [18:0] d;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] a;
  logic signed [16:0] b;
  logic               ovf_a;
  logic               ovf_b;

  int errors = 0;
  int checks = 0;

  svreal_sumdiff_decode dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .ovf_a(ovf_a), .ovf_b(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(
    input int si, input int di,
    output int ea, output int eb,
    output int eoa, output int eob
  );
    real sr, dr, ar, br, av, bv;
    sr = si / 1024.0;
    dr = di / 2048.0;
    ar = (sr + dr) / 2.0;
    br = (sr - dr) / 2.0;
    av = $floor(ar * 256.0 + 0.5);
    bv = $floor(br * 512.0 + 0.5);
    eoa = 0;
    eob = 0;
    if (av > 32767.0) begin av = 32767.0; eoa = 1; end
    if (av < -32768.0) begin av = -32768.0; eoa = 1; end
    if (bv > 65535.0) begin bv = 65535.0; eob = 1; end
    if (bv < -65536.0) begin bv = -65536.0; eob = 1; end
    ea = $rtoi(av);
    eb = $rtoi(bv);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    s = '0;
    d = '0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || a !== 16'sd0 || b !== 17'sd0 ||
        ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: v=%b a=%0d b=%0d oa=%b ob=%b want all 0",
               out_valid, a, b, ovf_a, ovf_b);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single(
    input int si, input int di,
    input int ea, input int eb,
    input bit eoa, input bit eob,
    input string nm
  );
    s = 18'(si);
    d = 19'(di);
    in_valid = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b want 0", nm, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || a !== 16'(ea) || b !== 17'(eb) ||
        ovf_a !== eoa || ovf_b !== eob) begin
      errors++;
      $display("FAIL %s: v=%b a=%0d b=%0d oa=%b ob=%b want v=1 a=%0d b=%0d oa=%b ob=%b",
               nm, out_valid, a, b, ovf_a, ovf_b, ea, eb, eoa, eob);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_dup: out_valid=%b want 0", nm, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    s = 18'sd4792;
    d = -19'sd4547;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy0: got %b want 1", in_ready);
    end
    step();
    s = 18'sd0;
    d = 19'sd262143;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy1: got %b want 1", in_ready);
    end
    step();
    s = -18'sd1;
    d = -19'sd1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
        a !== 16'sd315 || b !== 17'sd1766) begin
      errors++;
      $display("FAIL bp_full: rdy=%b v=%b a=%0d b=%0d want 0 1 315 1766",
               in_ready, out_valid, a, b);
    end
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
        a !== 16'sd315 || b !== 17'sd1766) begin
      errors++;
      $display("FAIL bp_hold: rdy=%b v=%b a=%0d b=%0d want 0 1 315 1766",
               in_ready, out_valid, a, b);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || a !== 16'sd16384 || b !== -17'sd32768) begin
      errors++;
      $display("FAIL bp_out1: v=%b a=%0d b=%0d want 1 16384 -32768",
               out_valid, a, b);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || a !== 16'sd0 || b !== 17'sd0) begin
      errors++;
      $display("FAIL bp_out2: v=%b a=%0d b=%0d want 1 0 0",
               out_valid, a, b);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ps[20];
    int pd[20];
    int ea[20];
    int eb[20];
    int eoa[20];
    int eob[20];
    int got;
    logic signed [17:0] st;
    logic signed [18:0] dt;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      st = 18'($urandom_range(0, 262143));
      dt = 19'($urandom_range(0, 524287));
      ps[i] = int'(st);
      pd[i] = int'(dt);
      model(ps[i], pd[i], ea[i], eb[i], eoa[i], eob[i]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        in_valid = 1'b1;
        s = 18'(ps[c]);
        d = 19'(pd[c]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      checks++;
      if (out_valid !== ((c >= 1) && (c <= 20))) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b want %b",
                 c, out_valid, (c >= 1) && (c <= 20));
      end
      if (out_valid === 1'b1 && c >= 1 && c <= 20) begin
        got++;
        checks++;
        if (a !== 16'(ea[c-1]) || b !== 17'(eb[c-1]) ||
            ovf_a !== 1'(eoa[c-1]) || ovf_b !== 1'(eob[c-1])) begin
          errors++;
          $display("FAIL b2b_data[%0d]: a=%0d b=%0d oa=%b ob=%b want %0d %0d %0d %0d",
                   c - 1, a, b, ovf_a, ovf_b,
                   ea[c-1], eb[c-1], eoa[c-1], eob[c-1]);
        end
      end
    end
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 20", got);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    s = 18'sd4792;
    d = -19'sd4547;
    step();
    s = 18'sd131071;
    d = 19'sd262143;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        a !== 16'sd0 || b !== 17'sd0 ||
        ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL midrst: v=%b rdy=%b a=%0d b=%0d oa=%b ob=%b want 0 1 0 0 0 0",
               out_valid, in_ready, a, b, ovf_a, ovf_b);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_ghost: %0d outputs after reset want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single(4792, -4547, 315, 1766, 1'b0, 1'b0, "basic");
    test_single(131071, 262143, 32767, 0, 1'b1, 1'b0, "sat_a");
    test_single(0, 0, 0, 0, 1'b0, 1'b0, "zero");
    test_single(-1, -1, 0, 0, 1'b0, 1'b0, "half_up");
    test_single(131071, -262144, 0, 65535, 1'b0, 1'b1, "sat_b");
    test_single(-131072, -262144, -32768, 0, 1'b0, 1'b0, "min_a");
    test_single(0, 262143, 16384, -32768, 1'b0, 1'b0, "neg_b");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
